// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared constants for the CPU data-memory slice.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_W             = 32;
  localparam int DMEM_ND_DEFAULT    = 3;
  localparam int DMEM_DEPTH_DEFAULT = 1024;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/data_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_if
// Purpose  : MEM-stage request/response bundle between pipeline and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface data_memory_if;
  import mem_pkg::*;

  logic              MemWrite;
  logic [WORD_W-1:0] Address;
  logic [WORD_W-1:0] WriteData;
  logic [WORD_W-1:0] ReadData;
  logic              MemReady;

  // Pipeline side issues requests and consumes the result
  modport master (
    output MemWrite, Address, WriteData,
    input  ReadData, MemReady
  );

  // Memory side serves requests
  modport slave (
    input  MemWrite, Address, WriteData,
    output ReadData, MemReady
  );

endinterface : data_memory_if
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : DEPTH x WORD_W storage, synchronous write, combinational read.
//            Contents are deliberately not reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Commit a write on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : dmem_array
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : Slow data memory for the MEM stage. Writes complete in one
//            clock; reads complete ND clocks after acceptance and raise
//            MemReady so hazard logic can stall on it.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory
  import mem_pkg::*;
#(
  parameter int ND    = DMEM_ND_DEFAULT,
  parameter int DEPTH = DMEM_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  data_memory_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ND + 1);
  localparam logic [CW-1:0] C_ND  = CW'(ND);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [WORD_W-1:0] raddr_q, raddr_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              ready_q,  ready_d;
  logic [WORD_W-1:0] rdata_q,  rdata_d;
  logic [WORD_W-1:0] arr_rdata;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (bus.MemWrite),
    .waddr (bus.Address[AW+1:2]),
    .wdata (bus.WriteData),
    .raddr (raddr_q[AW+1:2]),
    .rdata (arr_rdata)
  );

  // Request sequencing: writes abort reads; a new or changed read address
  // restarts the countdown; the last count step captures the array word.
  always_comb begin
    raddr_d  = raddr_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    ready_d  = ready_q;
    rdata_d  = rdata_q;
    if (bus.MemWrite) begin
      ready_d  = 1'b1;
      rvalid_d = 1'b0;
      cnt_d    = '0;
    end else if (!rvalid_q || (bus.Address != raddr_q)) begin
      raddr_d  = bus.Address;
      cnt_d    = C_ND;
      ready_d  = 1'b0;
      rvalid_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - C_ONE;
      if (cnt_q == C_ONE) begin
        rdata_d = arr_rdata;
        ready_d = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      raddr_q  <= raddr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.MemReady = ready_q;

endmodule : data_memory
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Purpose  : Directed self-checking bench for data_memory (ND=3, DEPTH=1024).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  localparam int DEPTH = 1024;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  data_memory_if bus();

  data_memory #(
    .ND    (3),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one active edge; return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.Address   = addr;
    bus.WriteData = data;
  endtask

  task automatic drive_read(input logic [31:0] addr);
    bus.MemWrite  = 1'b0;
    bus.Address   = addr;
    bus.WriteData = 32'd0;
  endtask

  // From acceptance edge: MemReady low for 3 edges, then high with data
  task automatic expect_read(input string tag, input logic [31:0] exp_data);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, "_busy"}, {31'd0, bus.MemReady}, 32'd0);
    end
    tick();
    check({tag, "_ready"}, {31'd0, bus.MemReady}, 32'd1);
    check({tag, "_data"}, bus.ReadData, exp_data);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    drive_read(32'd0);

    // Reset asserted away from any clock edge
    #3 rst_n = 1'b0;
    #1;
    check("reset_ready", {31'd0, bus.MemReady}, 32'd0);
    check("reset_data", bus.ReadData, 32'd0);
    tick();
    rst_n = 1'b1;

    // Two writes then a read of the first
    drive_write(32'd64, 32'd45);
    tick();
    check("wr1_ready", {31'd0, bus.MemReady}, 32'd1);
    drive_write(32'd128, 32'd100);
    tick();
    check("wr2_ready", {31'd0, bus.MemReady}, 32'd1);
    check("wr2_data_unchanged", bus.ReadData, 32'd0);
    drive_read(32'd64);
    expect_read("rd64", 32'd45);
    tick();
    check("rd64_hold_ready", {31'd0, bus.MemReady}, 32'd1);
    check("rd64_hold_data", bus.ReadData, 32'd45);

    // Address change without an intervening write
    drive_read(32'd128);
    expect_read("rd128", 32'd100);

    // Read at 64 aborted after one cycle by a switch to 128
    drive_read(32'd64);
    tick();
    check("abort_accept_ready", {31'd0, bus.MemReady}, 32'd0);
    drive_read(32'd128);
    expect_read("abort_rd128", 32'd100);

    // Write during a pending read restarts the read with full latency
    drive_read(32'd64);
    tick();
    check("wdr_pending_ready", {31'd0, bus.MemReady}, 32'd0);
    drive_write(32'd64, 32'd7);
    tick();
    check("wdr_write_ready", {31'd0, bus.MemReady}, 32'd1);
    check("wdr_write_data_held", bus.ReadData, 32'd100);
    drive_read(32'd64);
    expect_read("wdr_reread", 32'd7);

    // Address wrap modulo DEPTH words
    drive_write(32'(DEPTH * 4 + 64), 32'd9);
    tick();
    check("wrap_write_ready", {31'd0, bus.MemReady}, 32'd1);
    drive_read(32'd64);
    expect_read("wrap_rd64", 32'd9);
    tick();
    check("wrap_hold_data", bus.ReadData, 32'd9);

    // Asynchronous reset mid-cycle with live outputs
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ready", {31'd0, bus.MemReady}, 32'd0);
    check("async_reset_data", bus.ReadData, 32'd0);
    tick();
    rst_n = 1'b1;

    // First read after reset release is accepted immediately
    drive_read(32'd128);
    expect_read("post_reset_rd128", 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_data_memory
`default_nettype wire
